// File: rtl/alu_cmd_sequencer_if.sv
// Handshake bundle between the command source, the byte-operand ALU and the
// result consumer of alu_cmd_sequencer. The sequencer takes the slave view.
interface alu_cmd_sequencer_if;
  // Command channel
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic        cmd_ready;
  // ALU channel
  logic [2:0]  alu_operation;
  logic        alu_valid;
  logic [10:0] alu_result;
  logic        alu_ready;
  // Result channel
  logic        out_valid;
  logic [10:0] out_result;
  logic [2:0]  out_op;
  logic [3:0]  out_tag;
  logic        out_err;
  logic        out_ready;
  // Status
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_tag, alu_valid, alu_result, out_ready,
    output cmd_ready, alu_operation, alu_ready, out_valid, out_result,
           out_op, out_tag, out_err, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_tag, alu_valid, alu_result, out_ready,
    input  cmd_ready, alu_operation, alu_ready, out_valid, out_result,
           out_op, out_tag, out_err, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the byte-operand ALU: queues {op, tag} commands,
// issues one op at a time to the ALU, takes its result with ready/valid and
// forwards it, in command order, through a registered output slot.
// Optional macro ALU_CMD_TIMEOUT_EN: a command whose ALU result does not
// arrive within TIMEOUT_CYCLES WAIT cycles completes with result 11'h7FF and
// out_err set.
module alu_cmd_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rstn,
  alu_cmd_sequencer_if.slave  bus
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] tag;
  } cmd_t;

  cmd_t             fifo_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  state_e           state_q;
  logic [2:0]       alu_op_q;
  logic             out_valid_q;
  logic [10:0]      out_result_q;
  logic [2:0]       out_op_q;
  logic [3:0]       out_tag_q;

  cmd_t head;
  logic push, pop, slot_free, alu_fire, done_timeout;

  assign head      = fifo_q[rd_ptr_q];
  assign push      = bus.cmd_valid & bus.cmd_ready;
  assign slot_free = !out_valid_q | bus.out_ready;
  // alu_ready is built only from state and the output slot, never from
  // alu_valid, so the ALU's op-dependent valid cannot close a loop here.
  assign alu_fire  = bus.alu_valid & bus.alu_ready;
  assign pop       = alu_fire | done_timeout;

  assign bus.cmd_ready     = (count_q != CNT_W'(CMD_DEPTH));
  assign bus.alu_ready     = (state_q == ST_WAIT) & slot_free;
  assign bus.alu_operation = alu_op_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_op        = out_op_q;
  assign bus.out_tag       = out_tag_q;
  assign bus.busy          = (state_q != ST_IDLE) | (count_q != '0) | out_valid_q;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer_q;
  logic             out_err_q;

  assign done_timeout = (state_q == ST_WAIT) & !alu_fire & slot_free &
                        (timer_q == TMR_W'(TIMEOUT_CYCLES));
  assign bus.out_err  = out_err_q;

  // WAIT-cycle counter: held at zero in IDLE, saturates at the limit so a
  // blocked output slot simply delays the timeout completion.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer_q <= '0;
    end else if (state_q == ST_IDLE || pop) begin
      timer_q <= '0;
    end else if (timer_q != TMR_W'(TIMEOUT_CYCLES)) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Error flag travels with the output slot contents.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_err_q <= 1'b0;
    end else if (pop) begin
      out_err_q <= done_timeout;
    end
  end
`else
  assign done_timeout = 1'b0;
  assign bus.out_err  = 1'b0;
`endif

  // FIFO storage: written on push only.
  // NOTE: the data array has no reset; validity is carried entirely by
  // count_q, so resetting it would only add reset fan-out to a memory.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{op: bus.cmd_op, tag: bus.cmd_tag};
    end
  end

  // FIFO pointers and occupancy; push and pop together keep the count.
  // NOTE: every sequential assignment uses <= so all registers update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue/wait FSM with the registered ALU op and output slot.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      alu_op_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
      out_tag_q    <= '0;
    end else begin
      if (pop) begin
        out_valid_q  <= 1'b1;
        out_result_q <= alu_fire ? bus.alu_result : 11'h7FF;
        out_op_q     <= head.op;
        out_tag_q    <= head.tag;
      end else if (bus.out_ready) begin
        out_valid_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            alu_op_q <= head.op;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pop) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer. A queue-based model tracks
// accepted commands and completed results; directed tasks cover reset,
// latency, back-pressure, full FIFO, ordering and the timeout option, and a
// randomized run exercises the whole handshake space.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  bit sb_en        = 1'b1;
  int since_fire   = 0;
  int n_accept     = 0;

  typedef struct { logic [2:0] op; logic [3:0] tag; } cmd_t;
  typedef struct { logic [10:0] res; logic [2:0] op; logic [3:0] tag; } res_t;

  cmd_t       cmd_q[$];     // accepted, result not yet taken from the ALU
  res_t       res_q[$];     // taken from the ALU, not yet drained downstream
  logic [3:0] drain_log[$]; // tags in the order they left the block

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: observe at the falling edge, update the model with the
  // handshakes that the next rising edge will commit, then step past it.
  task automatic tick();
    res_t r;
    @(negedge clk);
    if (rstn && sb_en) begin
      tests_run++;
      if (bus.cmd_ready !== (cmd_q.size() != DEPTH)) begin
        tests_failed++;
        $display("FAIL sb_cmd_ready: got %b expected %b", bus.cmd_ready, cmd_q.size() != DEPTH);
      end
      tests_run++;
      if (bus.out_valid !== (res_q.size() != 0)) begin
        tests_failed++;
        $display("FAIL sb_out_valid: got %b expected %b", bus.out_valid, res_q.size() != 0);
      end
      if (bus.out_valid === 1'b1 && res_q.size() != 0) begin
        tests_run++;
        if ({bus.out_result, bus.out_op, bus.out_tag, bus.out_err} !==
            {res_q[0].res, res_q[0].op, res_q[0].tag, 1'b0}) begin
          tests_failed++;
          $display("FAIL sb_out_data: got res=%h op=%0d tag=%0d err=%b expected res=%h op=%0d tag=%0d err=0",
                   bus.out_result, bus.out_op, bus.out_tag, bus.out_err,
                   res_q[0].res, res_q[0].op, res_q[0].tag);
        end
      end
      tests_run++;
      if (bus.alu_ready === 1'b1 && (cmd_q.size() == 0 || (bus.out_valid && !bus.out_ready))) begin
        tests_failed++;
        $display("FAIL sb_alu_ready: got 1 expected 0 (pending=%0d out_valid=%b out_ready=%b)",
                 cmd_q.size(), bus.out_valid, bus.out_ready);
      end

      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && res_q.size() != 0) begin
        drain_log.push_back(res_q[0].tag);
        void'(res_q.pop_front());
      end
      if (bus.alu_valid === 1'b1 && bus.alu_ready === 1'b1) begin
        tests_run++;
        if (cmd_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_alu_fire: got handshake expected none (no pending command)");
        end else begin
          if (bus.alu_operation !== cmd_q[0].op) begin
            tests_failed++;
            $display("FAIL sb_alu_op: got %0d expected %0d", bus.alu_operation, cmd_q[0].op);
          end
          r.res = bus.alu_result;
          r.op  = cmd_q[0].op;
          r.tag = cmd_q[0].tag;
          res_q.push_back(r);
          void'(cmd_q.pop_front());
        end
        since_fire = 0;
      end else begin
        since_fire++;
      end
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        cmd_q.push_back('{op: bus.cmd_op, tag: bus.cmd_tag});
        n_accept++;
      end
    end else if (!rstn) begin
      cmd_q.delete();
      res_q.delete();
      since_fire = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tests_run++;
    if ({bus.out_valid, bus.alu_ready, bus.alu_operation, bus.cmd_ready, bus.busy,
         bus.out_err, bus.out_result, bus.out_op, bus.out_tag} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 11'd0, 3'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset_init: got ov=%b ar=%b aop=%0d cr=%b busy=%b err=%b res=%h op=%0d tag=%0d expected 0,0,0,1,0,0,0,0,0",
               bus.out_valid, bus.alu_ready, bus.alu_operation, bus.cmd_ready, bus.busy,
               bus.out_err, bus.out_result, bus.out_op, bus.out_tag);
    end
    // Park a command in WAIT with two more queued, then reset.
    bus.alu_valid = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_op  = 3'(i + 3);
      bus.cmd_tag = 4'(i + 1);
      tick();
    end
    bus.cmd_valid = 1'b0;
    tick();
    tests_run++;
    if (bus.alu_operation !== 3'd3 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_prewait: got aop=%0d busy=%b expected aop=3 busy=1", bus.alu_operation, bus.busy);
    end
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tests_run++;
    if ({bus.out_valid, bus.alu_ready, bus.alu_operation, bus.cmd_ready, bus.busy} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_midwait: got ov=%b ar=%b aop=%0d cr=%b busy=%b expected 0,0,0,1,0",
               bus.out_valid, bus.alu_ready, bus.alu_operation, bus.cmd_ready, bus.busy);
    end
    bus.alu_valid = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_lost: got ov=%b busy=%b expected 0,0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_latency();
    bus.out_ready  = 1'b1;
    bus.alu_valid  = 1'b1;
    bus.alu_result = 11'h1F4;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 3'd6;
    bus.cmd_tag    = 4'd3;
    tick();                      // edge 0: accept
    bus.cmd_valid  = 1'b0;
    tests_run++;
    if (bus.alu_operation !== 3'd0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat_edge0: got aop=%0d ov=%b expected 0,0", bus.alu_operation, bus.out_valid);
    end
    tick();                      // edge 1: issue
    tests_run++;
    if (bus.alu_operation !== 3'd6 || bus.alu_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat_edge1: got aop=%0d ar=%b ov=%b expected 6,1,0", bus.alu_operation, bus.alu_ready, bus.out_valid);
    end
    tick();                      // edge 2: handshake
    tests_run++;
    if ({bus.out_valid, bus.out_result, bus.out_op, bus.out_tag, bus.out_err} !== {1'b1, 11'h1F4, 3'd6, 4'd3, 1'b0}) begin
      tests_failed++;
      $display("FAIL lat_edge2: got ov=%b res=%h op=%0d tag=%0d err=%b expected 1,1f4,6,3,0",
               bus.out_valid, bus.out_result, bus.out_op, bus.out_tag, bus.out_err);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat_drain: got ov=%b busy=%b expected 0,0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready  = 1'b0;
    bus.alu_valid  = 1'b1;
    bus.alu_result = 11'h123;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 3'd0;
    bus.cmd_tag    = 4'd5;
    tick();
    bus.cmd_op     = 3'd1;
    bus.cmd_tag    = 4'd6;
    tick();
    bus.cmd_valid  = 1'b0;
    tick();
    bus.alu_result = 11'h456;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({bus.out_valid, bus.out_result, bus.out_op, bus.out_tag, bus.alu_ready} !== {1'b1, 11'h123, 3'd0, 4'd5, 1'b0}) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got ov=%b res=%h op=%0d tag=%0d ar=%b expected 1,123,0,5,0",
                 i, bus.out_valid, bus.out_result, bus.out_op, bus.out_tag, bus.alu_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.alu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got ar=%b expected 1", bus.alu_ready);
    end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.out_result, bus.out_op, bus.out_tag} !== {1'b1, 11'h456, 3'd1, 4'd6}) begin
      tests_failed++;
      $display("FAIL bp_second: got ov=%b res=%h op=%0d tag=%0d expected 1,456,1,6",
               bus.out_valid, bus.out_result, bus.out_op, bus.out_tag);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got ov=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_full();
    int start;
    int cyc;
    start         = drain_log.size();
    bus.out_ready = 1'b1;
    bus.alu_valid = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_op  = 3'(i);
      bus.cmd_tag = 4'(i + 1);
      tick();
    end
    bus.cmd_op  = 3'd4;
    bus.cmd_tag = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_ready[%0d]: got %b expected 0", i, bus.cmd_ready);
      end
      tick();
    end
    bus.alu_valid = 1'b1;
    tick();
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_reopen: got %b expected 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (drain_log.size() - start != 5) begin
      tests_failed++;
      $display("FAIL full_count: got %0d results expected 5", drain_log.size() - start);
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (drain_log[start + i] !== 4'(i + 1)) begin
          tests_failed++;
          $display("FAIL full_order[%0d]: got tag %0d expected %0d", i, drain_log[start + i], i + 1);
        end
      end
    end
  endtask

  task automatic test_order_toggle();
    int start;
    start         = drain_log.size();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.alu_valid = c[0];
      bus.cmd_valid = (c < 3);
      bus.cmd_op    = 3'($urandom_range(7));
      bus.cmd_tag   = 4'(c + 1);
      tick();
    end
    bus.cmd_valid = 1'b0;
    tests_run++;
    if (drain_log.size() - start != 3 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL order_count: got %0d results busy=%b expected 3 busy=0", drain_log.size() - start, bus.busy);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (drain_log[start + i] !== 4'(i + 1)) begin
          tests_failed++;
          $display("FAIL order_tag[%0d]: got %0d expected %0d", i, drain_log[start + i], i + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    int start_drain;
    int start_acc;
    int cyc;
    start_drain = drain_log.size();
    start_acc   = n_accept;
    for (int c = 0; c < 400; c++) begin
      bus.cmd_valid  = 1'($urandom_range(1));
      bus.cmd_op     = 3'($urandom_range(7));
      bus.cmd_tag    = 4'($urandom_range(15));
      bus.alu_result = 11'($urandom_range(2047));
      bus.alu_valid  = (since_fire >= 6) ? 1'b1 : ($urandom_range(3) != 0);
      bus.out_ready  = (since_fire >= 6) ? 1'b1 : ($urandom_range(3) != 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.alu_valid = 1'b1;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (bus.busy !== 1'b0 || cmd_q.size() != 0 || res_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_drain: got busy=%b pending=%0d held=%0d expected 0,0,0", bus.busy, cmd_q.size(), res_q.size());
    end
    tests_run++;
    if (drain_log.size() - start_drain != n_accept - start_acc) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d results expected %0d", drain_log.size() - start_drain, n_accept - start_acc);
    end
  endtask

  task automatic test_timeout();
    int n;
    sb_en         = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_valid = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd0;
    bus.cmd_tag   = 4'd9;
    tick();
    bus.cmd_valid = 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (n < TMO + 1 || n > TMO + 4) begin
      tests_failed++;
      $display("FAIL tmo_latency: got out_valid after %0d cycles expected %0d..%0d", n, TMO + 1, TMO + 4);
    end
    tests_run++;
    if ({bus.out_valid, bus.out_result, bus.out_err, bus.out_op, bus.out_tag} !== {1'b1, 11'h7FF, 1'b1, 3'd0, 4'd9}) begin
      tests_failed++;
      $display("FAIL tmo_result: got ov=%b res=%h err=%b op=%0d tag=%0d expected 1,7ff,1,0,9",
               bus.out_valid, bus.out_result, bus.out_err, bus.out_op, bus.out_tag);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_popped: got ov=%b busy=%b expected 0,0", bus.out_valid, bus.busy);
    end
`else
    n = 0;
    repeat (40) tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.alu_ready !== 1'b1 || bus.out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_tmo_wait: got ov=%b busy=%b ar=%b err=%b expected 0,1,1,0",
               bus.out_valid, bus.busy, bus.alu_ready, bus.out_err);
    end
`endif
    rstn = 1'b0;
    tick();
    tick();
    rstn  = 1'b1;
    sb_en = 1'b1;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_cleanup: got busy=%b expected 0 (n=%0d)", bus.busy, n);
    end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_tag    = '0;
    bus.alu_valid  = 1'b0;
    bus.alu_result = '0;
    bus.out_ready  = 1'b1;
    #1;
    test_reset();
    test_latency();
    test_backpressure();
    test_full();
    test_order_toggle();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Downstream consumer stage for the byte-operand ALU. Queues operation commands, each with an op code and a tag, and presents each op on the ALU's operation input. It then waits for the ALU's valid result, takes it with a ready/valid handshake, and passes the result on to a registered output port together with its op and tag. Results leave strictly in command order, and back-pressure from the output is carried through to the ALU.

Parameters:
CMD_DEPTH, 4, number of command FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 16, WAIT-state cycle limit; only used with the optional feature

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  reset, synchronous active-low
cmd_valid  in  1  command valid
cmd_op  in  3  ALU op code: 0 ADD2, 1 SUB2, 2 OR2, 3 AND2, 4 OR, 5 AND, 6 SUM, 7 AVG
cmd_tag  in  4  user tag returned with the result
cmd_ready  out  1  command accepted; equals (fifo count != CMD_DEPTH)
alu_operation  out  3  registered op driven to the ALU operation input
alu_valid  in  1  ALU result valid
alu_result  in  11  ALU result
alu_ready  out  1  ALU result ready
out_valid  out  1  result valid
out_result  out  11  captured result
out_op  out  3  op code of the result
out_tag  out  4  tag of the result
out_err  out  1  result produced by timeout (optional feature)
out_ready  in  1  downstream ready
busy  out  1  (state != IDLE) | (fifo count != 0) | out_valid

Behaviour:
- Decided interface: one clock; reset is synchronous and active-low. Ports are named clk and rstn.
- Reset (rstn=0 at a clock edge):
  - FIFO is emptied and state goes to IDLE.
  - alu_operation=0, out_valid=0, out_result=0, out_op=0, out_tag=0, out_err=0, alu_ready=0.
  - cmd_ready=1 from the first reset edge onward.
  - Reset wins over every other event, including in-flight handshakes. The command in progress is discarded.
- Command FIFO:
  - Push on cmd_valid & cmd_ready.
  - Read and write pointers wrap modulo CMD_DEPTH.
  - No push when full; there is no bypass.
  - Push and pop in the same cycle leave the count unchanged.
- FSM has two states, IDLE and WAIT.
  - IDLE: if the FIFO is non-empty, alu_operation <= head.op and go to WAIT. Otherwise stay in IDLE; alu_operation holds its last value.
  - WAIT: alu_ready = slot_free, where slot_free = !out_valid | out_ready.
    - On alu_valid & alu_ready: out_result <= alu_result, out_op <= head.op, out_tag <= head.tag, out_err <= 0, out_valid <= 1, pop the FIFO, go to IDLE.
    - In every state other than WAIT, alu_ready = 0.
    - alu_ready never depends combinationally on alu_valid. This avoids a loop with the ALU's op-dependent valid.
- Latency:
  - Command accepted at edge N, FIFO previously empty.
  - alu_operation valid after edge N+1; WAIT in the cycle after edge N+1; earliest ALU handshake at edge N+2.
  - out_valid high after edge N+2.
  - Sustained throughput is one result per 2 cycles.
- Output register:
  - out_valid drops on out_ready when no new capture happens in the same cycle.
  - A capture and a drain in the same cycle load the new value with out_valid staying 1.
  - out_* are stable while out_valid & !out_ready.
- Widths: result is 11 bits and passed through unmodified. Internally, count is clog2(CMD_DEPTH)+1 bits.

Optional Feature:
Macro: ALU_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without an ALU handshake.
  - If no handshake has happened once it reaches TIMEOUT_CYCLES, and slot_free holds, the command completes: out_result=11'h7FF, out_err=1, op and tag from the head, FIFO popped, state returns to IDLE.
  - This covers two-operand ops issued while the ALU holds fewer than two operands.
  - If slot_free is low at that point, completion is delayed until it is high.
- Undefined: no counter; WAIT lasts until the handshake; out_err is tied to 0.

Test Plan:
1. rstn=0 for 2 edges mid-WAIT with 2 commands queued -> out_valid=0, alu_ready=0, alu_operation=0, cmd_ready=1, busy=0; commands lost.
2. cmd op=6 tag=3 at edge 0; alu_valid=1, alu_result=0x1F4 -> alu_operation=6 after edge 1; alu_ready=1 in the cycle after edge 1; out_valid=1 after edge 2 with result 0x1F4, op 6, tag 3.
3. out_ready=0, two commands (ops 0 and 1), alu_valid=1 -> first result held stable; alu_ready=0 for the second until out_ready=1; second result follows on the next edge, in order.
4. alu_valid=0, push 5 commands on consecutive cycles -> first 4 accepted, cmd_ready=0 after the 4th; the 5th stays un-accepted until the first ALU handshake.
5. Tags 1,2,3 with alu_valid toggling every cycle -> out_tag sequence 1,2,3, each appearing exactly once.
6. With ALU_CMD_TIMEOUT_EN, op=0 and alu_valid held 0 -> after 16 WAIT cycles out_valid=1, out_result=0x7FF, out_err=1, FIFO popped. Without the macro, the block stays in WAIT indefinitely.
